param_counter: RTL

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_prescaler.sv | 43 ++++
 rtl/param_counter.sv | 91 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parameterised up/down counter.
package counter_pkg;

   localparam bit WRAP = 1'b0;
   localparam bit SAT  = 1'b1;

   // Highest reachable count: MODULUS-1, or all ones when MODULUS is 0.
   function automatic logic [31:0] last_value(input int unsigned width,
                                              input int unsigned modulus);
      logic [63:0] full;
      full = (64'd1 << width) - 64'd1;
      if (modulus == 0)
         return full[31:0];
      return modulus - 1;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-qualified prescaler: tick marks the enabled cycle that completes
// PRESCALE enables. With PRESCALE=1 tick is constantly high.
module counter_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic enable,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         logic unused_inputs;
         assign unused_inputs = &{1'b0, clk, reset_n, clr, enable};
         assign tick = 1'b1;
      end else begin : g_div
         localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

         logic [15:0] cnt_reg;
         logic [15:0] cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            if (clr)
               cnt_next = '0;
            else if (enable)
               cnt_next = (cnt_reg == PS_LAST) ? 16'd0 : cnt_reg + 16'd1;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               cnt_reg <= '0;
            else
               cnt_reg <= cnt_next;
         end

         assign tick = enable && (cnt_reg == PS_LAST);
      end
   endgenerate

endmodule

// File: rtl/param_counter.sv
// Parameterised up/down counter with modulus, prescaler, wrap/saturate mode,
// terminal-count pulse and sticky boundary flag.
module param_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned MODULUS  = 0,
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf_sticky
);

   localparam logic [WIDTH-1:0] LAST     = WIDTH'(last_value(WIDTH, MODULUS));
   localparam bit               SAT_MODE = ((SATURATE != 0) ? SAT : WRAP) == SAT;
   localparam bit               MODULUS_BAD =
      (MODULUS == 1) || (64'(MODULUS) > (64'd1 << WIDTH));

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             tc_reg;
   logic             tc_next;
   logic             ovf_reg;
   logic             ovf_next;
   logic             tick;
   logic             at_bound;

   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clear | load),
      .enable  (enable),
      .tick    (tick)
   );

   assign at_bound = up ? (count_reg == LAST) : (count_reg == '0);

   always_comb begin
      count_next = count_reg;
      tc_next    = 1'b0;
      ovf_next   = ovf_reg;
      if (ovf_clr)
         ovf_next = 1'b0;
      if (clear) begin
         count_next = '0;
      end else if (load) begin
         count_next = (load_value > LAST) ? LAST : load_value;
      end else if (enable && tick) begin
         if (at_bound) begin
            // A boundary attempt flags tc/ovf whether it wraps or holds.
            tc_next  = 1'b1;
            ovf_next = 1'b1;
            if (!SAT_MODE)
               count_next = up ? '0 : LAST;
         end else begin
            count_next = up ? count_reg + WIDTH'(1) : count_reg - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
         tc_reg    <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         tc_reg    <= tc_next;
         ovf_reg   <= ovf_next;
      end
   end

   assign count      = count_reg;
   assign tc         = tc_reg;
   assign ovf_sticky = ovf_reg;

   a_modulus_legal: assert property (@(posedge clk) !MODULUS_BAD);

endmodule
